sub_result_fifo: RTL and testbench

Buffering stage directly downstream of the 4-bit two's-complement subtraction unit. Captures each difference together with its operands, derives zero/negative/signed-overflow flags at write time, and holds up to DEPTH results in a FIFO drained by a valid/ready consumer (display or bus interface). Also keeps a saturating count of overflowed results since reset.

---
 rtl/sub_result_fifo.sv | 86 ++++++++
 tb/tb_sub_result_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_result_fifo.sv
// rtl/sub_result_fifo.sv - result FIFO behind the 4-bit subtractor with per-entry flags and overflow count
module sub_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 x,
    input  logic [3:0]                 y,
    input  logic [3:0]                 d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_d,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           ovf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    head;
    logic          push;
    logic          pop;
    logic          in_zero;
    logic          in_neg;
    logic          in_ovf;

    // Ready/valid come only from the stored level, so a full FIFO never
    // accepts on the strength of a same-cycle pop.
    assign in_ready  = (level < FULL_LEVEL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Signed overflow of x - y: operands differ in sign and the result sign
    // disagrees with the minuend.
    assign in_zero = (d == 4'b0000);
    assign in_neg  = d[3];
    assign in_ovf  = (x[3] != y[3]) && (d[3] != x[3]);

    assign head     = mem[rd_ptr];
    assign out_d    = head[6:3];
    assign out_zero = head[2];
    assign out_neg  = head[1];
    assign out_ovf  = head[0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {d, in_zero, in_neg, in_ovf};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (push && in_ovf && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sub_result_fifo.sv
// tb/tb_sub_result_fifo.sv - scoreboard bench for sub_result_fifo
module tb_sub_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [3:0] d = '0;

    logic       in_ready, out_valid, out_zero, out_neg, out_ovf;
    logic [3:0] out_d;
    logic [2:0] level;
    logic [7:0] ovf_count;

    logic       in_ready2, out_valid2, out_zero2, out_neg2, out_ovf2;
    logic [3:0] out_d2;
    logic [2:0] level2;
    logic [1:0] ovf_count2;

    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    sub_result_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .level(level), .ovf_count(ovf_count)
    );

    // Narrow counter copy, used for the saturation scenario.
    sub_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .d(d), .out_valid(out_valid2), .out_ready(out_ready),
        .out_d(out_d2), .out_zero(out_zero2), .out_neg(out_neg2), .out_ovf(out_ovf2),
        .level(level2), .ovf_count(ovf_count2)
    );

    function automatic logic [6:0] model(input logic [3:0] xx, input logic [3:0] yy, input logic [3:0] dd);
        return {dd, (dd == 4'd0), dd[3], ((xx[3] != yy[3]) && (dd[3] != xx[3]))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle and keeps the scoreboard in step using the bench's own depth.
    task automatic step(input logic v, input logic [3:0] xx, input logic [3:0] yy,
                        input logic [3:0] dd, input logic r);
        logic do_pop;
        logic do_push;
        in_valid  = v;
        x         = xx;
        y         = yy;
        d         = dd;
        out_ready = r;
        do_pop  = r && (exp_q.size() != 0);
        do_push = v && (exp_q.size() < DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(model(xx, yy, dd));
        tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (ovf_count !== 8'd0) begin miscompares++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
        vectors++; if (ovf_count2 !== 2'd0) begin miscompares++; $display("FAIL reset_ovf_count_sat: got %0d expected 0", ovf_count2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 4'd7, 4'hF, 4'h8, 1'b0);
        step(1'b1, 4'd2, 4'd1, 4'd1, 1'b0);
        step(1'b1, 4'd3, 4'd1, 4'd2, 1'b0);
        vectors++; if (level !== 3'd3) begin miscompares++; $display("FAIL mid_level_pre: got %0d expected 3", level); end
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL mid_level: got %0d expected 0", level); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        vectors++; if (ovf_count !== 8'd0) begin miscompares++; $display("FAIL mid_ovf_count: got %0d expected 0", ovf_count); end
        step(1'b1, 4'd6, 4'd2, 4'd4, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_first_valid: got %b expected 1", out_valid); end
        vectors++; if ({out_d, out_zero, out_neg, out_ovf} !== exp_q[0]) begin miscompares++; $display("FAIL mid_first_head: got %h expected %h", {out_d, out_zero, out_neg, out_ovf}, exp_q[0]); end
    endtask

    task automatic test_flags();
        logic [3:0] xs [5];
        logic [3:0] ys [5];
        logic [3:0] ds [5];
        logic [2:0] fl [5];
        int         k;
        xs = '{4'd5, 4'd3, 4'd2, 4'd7, 4'h8};
        ys = '{4'd3, 4'd3, 4'd5, 4'hF, 4'd1};
        ds = '{4'd2, 4'd0, 4'hD, 4'h8, 4'd7};
        fl = '{3'b000, 3'b100, 3'b010, 3'b011, 3'b001};
        k  = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            vectors++; if (out_valid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL flags_valid[%0d]: got %b expected %b", i, out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                vectors++; if ({out_d, out_zero, out_neg, out_ovf} !== exp_q[0]) begin miscompares++; $display("FAIL flags_head[%0d]: got %h expected %h", i, {out_d, out_zero, out_neg, out_ovf}, exp_q[0]); end
                vectors++; if ({out_zero, out_neg, out_ovf} !== fl[k]) begin miscompares++; $display("FAIL flags_bits[%0d]: got %b expected %b", k, {out_zero, out_neg, out_ovf}, fl[k]); end
                k++;
            end
            step(i < 5, xs[i % 5], ys[i % 5], ds[i % 5], 1'b1);
        end
        vectors++; if (k != 5) begin miscompares++; $display("FAIL flags_pop_count: got %0d expected 5", k); end
        vectors++; if (ovf_count !== 8'd2) begin miscompares++; $display("FAIL flags_ovf_count: got %0d expected 2", ovf_count); end
    endtask

    task automatic test_full();
        logic d5_in;
        logic will_accept;
        int   order_k;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 4'd0, 4'(i + 1), 1'b0);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (level !== 3'd4) begin miscompares++; $display("FAIL full_level[%0d]: got %0d expected 4", i, level); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready[%0d]: got %b expected 0", i, in_ready); end
            step(1'b1, 4'd0, 4'd0, 4'd5, 1'b0);
        end
        d5_in   = 1'b0;
        order_k = 1;
        for (int c = 0; c < 7; c++) begin
            vectors++; if (in_ready !== (exp_q.size() < DEPTH)) begin miscompares++; $display("FAIL drain_in_ready[%0d]: got %b expected %b", c, in_ready, exp_q.size() < DEPTH); end
            if (exp_q.size() != 0) begin
                vectors++; if ({out_d, out_zero, out_neg, out_ovf} !== exp_q[0]) begin miscompares++; $display("FAIL drain_head[%0d]: got %h expected %h", c, {out_d, out_zero, out_neg, out_ovf}, exp_q[0]); end
                vectors++; if (out_d !== 4'(order_k)) begin miscompares++; $display("FAIL drain_order[%0d]: got %0d expected %0d", c, out_d, order_k); end
                order_k++;
            end
            will_accept = !d5_in && (exp_q.size() < DEPTH);
            step(!d5_in, 4'd0, 4'd0, 4'd5, 1'b1);
            if (will_accept) d5_in = 1'b1;
        end
        vectors++; if (order_k != 6) begin miscompares++; $display("FAIL drain_count: got %0d expected 6", order_k); end
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 4'd0, 4'd0, 4'd1, 1'b0);
        step(1'b1, 4'd0, 4'd0, 4'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++; if (level !== 3'd2) begin miscompares++; $display("FAIL b2b_level[%0d]: got %0d expected 2", i, level); end
            vectors++; if (out_d !== 4'(i + 1)) begin miscompares++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, out_d, i + 1); end
            step(1'b1, 4'd0, 4'd0, 4'(i + 3), 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++; if ({out_d, out_zero, out_neg, out_ovf} !== exp_q[0]) begin miscompares++; $display("FAIL b2b_tail[%0d]: got %h expected %h", i, {out_d, out_zero, out_neg, out_ovf}, exp_q[0]); end
            vectors++; if (out_d !== 4'(i + 11)) begin miscompares++; $display("FAIL b2b_tail_d[%0d]: got %0d expected %0d", i, out_d, i + 11); end
            step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        end
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL b2b_final_level: got %0d expected 0", level); end
    endtask

    task automatic test_empty_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL stall_level[%0d]: got %0d expected 0", i, level); end
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, out_valid); end
        end
        step(1'b1, 4'd3, 4'd5, 4'hE, 1'b1);
        vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL stall_push_level: got %0d expected 1", level); end
        vectors++; if ({out_d, out_zero, out_neg, out_ovf} !== exp_q[0]) begin miscompares++; $display("FAIL stall_head: got %h expected %h", {out_d, out_zero, out_neg, out_ovf}, exp_q[0]); end
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL stall_pop_level: got %0d expected 0", level); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_pop_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        int sat;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 4'd7, 4'hF, 4'h8, 1'b1);
            sat = (k < 3) ? k : 3;
            vectors++; if (ovf_count !== 8'(k)) begin miscompares++; $display("FAIL sat_wide[%0d]: got %0d expected %0d", k, ovf_count, k); end
            vectors++; if (ovf_count2 !== 2'(sat)) begin miscompares++; $display("FAIL sat_narrow[%0d]: got %0d expected %0d", k, ovf_count2, sat); end
        end
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        vectors++; if (ovf_count2 !== 2'd3) begin miscompares++; $display("FAIL sat_after_pop: got %0d expected 3", ovf_count2); end
        vectors++; if (ovf_count !== 8'd5) begin miscompares++; $display("FAIL sat_wide_after_pop: got %0d expected 5", ovf_count); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_flags();
        test_full();
        test_back_to_back();
        test_empty_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
